// File: rtl/counter_slice_scheduler.sv
// counter_slice_scheduler
// Round-robin owner of a shared 4-bit slice counter. One requester holds the
// grant at a time. A slice ends on done, on a dropped request, or when
// slice_cnt reaches QUANTUM. At least one idle cycle always separates grants.
// Optional macro SCHED_PRIORITY_EN: requester 0 always wins arbitration, is
// exempt from quantum expiry (its count saturates at 15), and its release
// leaves the round-robin pointer untouched.
module counter_slice_scheduler #(
   parameter int ID_W    = 2,
   parameter int QUANTUM = 15,
   localparam int N_REQ  = 2**ID_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_REQ-1:0]  i_req,
   input  logic [N_REQ-1:0]  i_done,
   output logic [N_REQ-1:0]  o_gnt,
   output logic [ID_W-1:0]   o_gnt_id,
   output logic [3:0]        o_slice_cnt,
   output logic              o_slice_expired,
   output logic              o_busy
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t            r_state;
   logic [ID_W-1:0]   r_ptr;
   logic [N_REQ-1:0]  r_gnt;
   logic [ID_W-1:0]   r_gnt_id;
   logic [3:0]        r_slice_cnt;
   logic              r_expired;
   logic              r_busy;

   state_t            w_state_next;
   logic [ID_W-1:0]   w_ptr_next;
   logic [N_REQ-1:0]  w_gnt_next;
   logic [ID_W-1:0]   w_gnt_id_next;
   logic [3:0]        w_cnt_next;
   logic              w_expired_next;

   logic [ID_W-1:0]   w_cand [N_REQ];
   logic              w_found;
   logic [ID_W-1:0]   w_winner;
   logic              w_exempt;

   // Candidate order for arbitration: ptr, ptr+1, ... wrapping naturally
   // because N_REQ is a power of two.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_cand
         assign w_cand[gi] = r_ptr + ID_W'(gi);
      end
   endgenerate

`ifdef SCHED_PRIORITY_EN
   assign w_exempt = (r_gnt_id == '0);
`else
   assign w_exempt = 1'b0;
`endif

   // First requesting index at or after ptr (requester 0 first in priority mode).
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (i_req[w_cand[i]]) begin
            w_found  = 1'b1;
            w_winner = w_cand[i];
         end
      end
`ifdef SCHED_PRIORITY_EN
      if (i_req[0]) begin
         w_winner = '0;
      end
`endif
   end

   // Next-state logic: arbitrate in IDLE, count and watch release conditions in GRANT.
   always_comb begin
      w_state_next   = r_state;
      w_ptr_next     = r_ptr;
      w_gnt_id_next  = r_gnt_id;
      w_cnt_next     = r_slice_cnt;
      w_expired_next = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_next  = ST_GRANT;
               w_gnt_id_next = w_winner;
               w_cnt_next    = 4'd0;
            end
         end
         ST_GRANT: begin
            if (i_done[r_gnt_id] || !i_req[r_gnt_id] ||
                (r_slice_cnt == 4'(QUANTUM) && !w_exempt)) begin
               // Expiry only flags when no normal release competes with it.
               w_expired_next = !(i_done[r_gnt_id] || !i_req[r_gnt_id]);
               w_state_next   = ST_IDLE;
               w_gnt_id_next  = '0;
               w_cnt_next     = 4'd0;
               if (!w_exempt) begin
                  w_ptr_next = r_gnt_id + ID_W'(1);
               end
            end else if (r_slice_cnt != 4'd15) begin
               w_cnt_next = r_slice_cnt + 4'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // One-hot decode of the next owner.
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
         assign w_gnt_next[gi] = (w_state_next == ST_GRANT) &&
                                 (w_gnt_id_next == ID_W'(gi));
      end
   endgenerate

   // State and output registers; reset wins over any request or release.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_gnt_id    <= '0;
         r_slice_cnt <= 4'd0;
         r_expired   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ptr       <= w_ptr_next;
         r_gnt       <= w_gnt_next;
         r_gnt_id    <= w_gnt_id_next;
         r_slice_cnt <= w_cnt_next;
         r_expired   <= w_expired_next;
         r_busy      <= (w_state_next == ST_GRANT);
      end
   end

   assign o_gnt           = r_gnt;
   assign o_gnt_id        = r_gnt_id;
   assign o_slice_cnt     = r_slice_cnt;
   assign o_slice_expired = r_expired;
   assign o_busy          = r_busy;

endmodule

// File: tb/tb_counter_slice_scheduler.sv
// Testbench for counter_slice_scheduler: directed scenarios plus random
// traffic, every cycle compared against a behavioural model of the scheduler.
module tb_counter_slice_scheduler;

   localparam int ID_W = 2;
   localparam int N    = 4;
   localparam int Q    = 15;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] done;
   logic [N-1:0] o_gnt;
   logic [ID_W-1:0] o_gnt_id;
   logic [3:0]   o_slice_cnt;
   logic         o_slice_expired;
   logic         o_busy;

   int checks = 0;
   int errors = 0;

   // Model state: owner index (-1 = nobody), slice count, pointer, expiry flag.
   int m_owner = -1;
   int m_cnt   = 0;
   int m_ptr   = 0;
   bit m_exp   = 1'b0;

   counter_slice_scheduler #(.ID_W(ID_W), .QUANTUM(Q)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_req           (req),
      .i_done          (done),
      .o_gnt           (o_gnt),
      .o_gnt_id        (o_gnt_id),
      .o_slice_cnt     (o_slice_cnt),
      .o_slice_expired (o_slice_expired),
      .o_busy          (o_busy)
   );

   always #5 clk = ~clk;

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_step();
      int  w;
      int  k;
      bit  exempt;
      if (reset) begin
         m_owner = -1; m_cnt = 0; m_ptr = 0; m_exp = 1'b0;
      end else if (m_owner < 0) begin
         m_exp = 1'b0;
         w = -1;
`ifdef SCHED_PRIORITY_EN
         if (req[0]) w = 0;
`endif
         for (int i = 0; i < N; i++)
            if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
         if (w >= 0) begin
            m_owner = w;
            m_cnt   = 0;
         end
      end else begin
         k = m_owner;
         exempt = 1'b0;
`ifdef SCHED_PRIORITY_EN
         exempt = (k == 0);
`endif
         if (done[k] || !req[k] || (m_cnt == Q && !exempt)) begin
            m_exp   = !(done[k] || !req[k]);
            m_owner = -1;
            m_cnt   = 0;
            if (!exempt) m_ptr = (k + 1) % N;
         end else begin
            m_exp = 1'b0;
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
         end
      end
   endtask

   function automatic logic [11:0] model_vec();
      logic [3:0] g;
      logic [1:0] id;
      g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
      id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      return {g, id, 4'(m_cnt), m_exp, (m_owner >= 0)};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {o_gnt, o_gnt_id, o_slice_cnt, o_slice_expired, o_busy};
   endfunction

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; done = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'b1111; done = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (dut_vec() !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: got %b required %b (gnt,id,cnt,exp,busy)", dut_vec(), 12'd0);
         end
      end
      reset = 1'b0; req = '0; done = '0;
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL reset_idle: got %b required %b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_grant_release();
      do_reset();
      req = 4'b0100;
      tick();
      checks++;
      if (o_gnt !== 4'b0100 || o_gnt_id !== 2'd2 || o_slice_cnt !== 4'd0) begin
         errors++;
         $display("FAIL first_grant: got gnt=%b id=%0d cnt=%0d required gnt=0100 id=2 cnt=0", o_gnt, o_gnt_id, o_slice_cnt);
      end
      for (int c = 0; c < 20 && o_slice_cnt !== 4'd3; c++) begin
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL grant_count: got %b required %b", dut_vec(), model_vec());
         end
      end
      done = 4'b0100;
      tick();
      done = '0;
      checks++;
      if (o_gnt !== 4'b0000 || o_busy !== 1'b0 || o_slice_expired !== 1'b0) begin
         errors++;
         $display("FAIL done_release: got gnt=%b busy=%b exp=%b required 0000 0 0", o_gnt, o_busy, o_slice_expired);
      end
      // Pointer should now favour requester 3.
      req = 4'b1111;
      tick();
      checks++;
      if (o_gnt_id !== 2'd3 || o_gnt !== 4'b1000) begin
         errors++;
         $display("FAIL ptr_after_done: got id=%0d gnt=%b required id=3 gnt=1000", o_gnt_id, o_gnt);
      end
      req = '0;
      tick();
   endtask

   task automatic test_round_robin();
      int order[$];
      int expect_order[5] = '{0, 1, 2, 3, 0};
      int pulses = 0;
      int len = 0;
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 85; c++) begin
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL rr_cycle%0d: got %b required %b", c, dut_vec(), model_vec());
         end
         if (o_busy && o_slice_cnt == 4'd0) order.push_back(int'(o_gnt_id));
         if (o_slice_expired) pulses++;
         if (o_busy) len++;
         else if (len > 0) begin
            checks++;
            if (len != Q + 1) begin
               errors++;
               $display("FAIL rr_slice_len: got %0d cycles required %0d", len, Q + 1);
            end
            len = 0;
         end
      end
      checks++;
      if (order.size() != 5) begin
         errors++;
         $display("FAIL rr_grant_count: got %0d grants required 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (order[i] != expect_order[i]) begin
               errors++;
               $display("FAIL rr_order[%0d]: got %0d required %0d", i, order[i], expect_order[i]);
            end
         end
      end
      checks++;
      if (pulses != 5) begin
         errors++;
         $display("FAIL rr_expired_pulses: got %0d required 5", pulses);
      end
      req = '0;
      tick();
   endtask

   task automatic test_done_at_quantum();
      do_reset();
      req = 4'b0010;
      tick();
      for (int c = 0; c < 40 && o_slice_cnt !== 4'(Q); c++) begin
         done = (o_slice_cnt == 4'd5) ? 4'b1000 : 4'b0000;
         tick();
         checks++;
         if (dut_vec() !== model_vec() || o_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL nonowner_done: got %b required %b", dut_vec(), model_vec());
         end
      end
      checks++;
      if (o_slice_cnt !== 4'(Q)) begin
         errors++;
         $display("FAIL quantum_reach: got cnt=%0d required %0d", o_slice_cnt, Q);
      end
      done = 4'b0010;
      tick();
      done = '0;
      checks++;
      if (o_gnt !== 4'b0000 || o_slice_expired !== 1'b0) begin
         errors++;
         $display("FAIL done_at_quantum: got gnt=%b exp=%b required 0000 0", o_gnt, o_slice_expired);
      end
      req = '0;
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL done_at_quantum_after: got %b required %b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 4'b0010;
      tick();
      for (int c = 0; c < 20 && o_slice_cnt !== 4'd7; c++) tick();
      checks++;
      if (o_gnt !== 4'b0010 || o_slice_cnt !== 4'd7) begin
         errors++;
         $display("FAIL mid_setup: got gnt=%b cnt=%0d required 0010 7", o_gnt, o_slice_cnt);
      end
      reset = 1'b1; req = 4'b0011; done = 4'b0010;
      tick();
      checks++;
      if (dut_vec() !== 12'd0) begin
         errors++;
         $display("FAIL mid_reset: got %b required %b", dut_vec(), 12'd0);
      end
      reset = 1'b0; done = '0;
      tick();
      checks++;
      if (o_gnt !== 4'b0001 || o_gnt_id !== 2'd0) begin
         errors++;
         $display("FAIL post_reset_grant: got gnt=%b id=%0d required 0001 0", o_gnt, o_gnt_id);
      end
      req = '0;
      tick();
   endtask

   task automatic test_abandon();
      do_reset();
      req = 4'b0100;
      tick();
      for (int c = 0; c < 20 && o_slice_cnt !== 4'd5; c++) tick();
      req = 4'b1000;
      tick();
      checks++;
      if (o_gnt !== 4'b0000 || o_slice_expired !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL abandon_release: got gnt=%b exp=%b busy=%b required 0000 0 0", o_gnt, o_slice_expired, o_busy);
      end
      tick();
      checks++;
      if (o_gnt !== 4'b1000 || o_gnt_id !== 2'd3) begin
         errors++;
         $display("FAIL abandon_next: got gnt=%b id=%0d required 1000 3", o_gnt, o_gnt_id);
      end
      req = '0;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         done = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         tick();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random_cycle%0d: got %b required %b (req=%b done=%b)", c, dut_vec(), model_vec(), req, done);
         end
      end
      reset = 1'b0; req = '0; done = '0;
      tick();
   endtask

   initial begin
      reset = 1'b1; req = '0; done = '0;
      test_reset();
      test_grant_release();
      test_round_robin();
      test_done_at_quantum();
      test_reset_mid_grant();
      test_abandon();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_slice_scheduler.md
# counter_slice_scheduler

Round-robin scheduler that shares one 4-bit slice counter among several requesters and grants the counter to one requester at a time. Each grant is a time slice: it lasts until the owner releases or the counter reaches the quantum limit, which ends the slice like a counter overflow. The block sits between requesting engines and the shared count/timing resource. It drives the one-hot grant, the owner index and the running slice count.

## Interface
- ID_W, 2, owner index width; number of requesters N_REQ = 2**ID_W (legal 1..3)
- QUANTUM, 15, last slice_cnt value of a slice (legal 1..15); a full slice holds the grant for QUANTUM+1 cycles

- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high
- req  input  N_REQ  request per requester, level; held until granted and served
- done  input  N_REQ  release strobe from a requester; honoured only for the current owner
- gnt  output  N_REQ  one-hot grant, all-zero when idle
- gnt_id  output  ID_W  index of current owner; 0 when idle
- slice_cnt  output  4  cycles elapsed in current slice, 0 when idle
- slice_expired  output  1  one-cycle pulse when a slice ends by quantum
- busy  output  1  high while any grant is active

## Operation
- State machine has two states: IDLE and GRANT. Registered pointer ptr (ID_W bits) holds the highest-priority index for the next arbitration.
- IDLE: if req is non-zero, select the first set bit searching ptr, ptr+1, … modulo N_REQ. Go to GRANT with gnt/gnt_id set to the winner and slice_cnt=0. If req is zero, stay in IDLE.
- GRANT: slice_cnt increments by 1 each cycle. Release conditions for owner k, checked in priority order:
  - done[k]=1: normal release.
  - req[k]=0: abandoned, same as done.
  - slice_cnt==QUANTUM: expiry; slice_expired=1 for the cycle after the edge.
- On any release: next state is IDLE, gnt=0, gnt_id=0, slice_cnt=0, busy=0, ptr=k+1 modulo N_REQ.
- done and expiry in the same cycle count as a normal release, and slice_expired stays low.
- done bits of non-owners are ignored.
- slice_cnt never wraps. It stops at QUANTUM because release is forced.
- At least one IDLE cycle always separates consecutive grants, including grants to the same requester.
- Reset values: state=IDLE, ptr=0, gnt=0, gnt_id=0, slice_cnt=0, slice_expired=0, busy=0.

## Timing
- All outputs are registered.
- req sampled at edge t while IDLE → gnt high from edge t onward, which is 1 cycle of latency.
- Release condition sampled at edge t → gnt low after edge t. The earliest next grant is after edge t+1.
- A full slice holds gnt for exactly QUANTUM+1 cycles, with slice_cnt values 0..QUANTUM.
- slice_expired is high only in the first IDLE cycle after an expiry.
- Reset asserted mid-GRANT: all outputs reach reset values after that edge, and no slice_expired pulse occurs. Reset overrides req and done in the same cycle.

## Configuration
- SCHED_PRIORITY_EN defined:
  - In IDLE, req[0] wins regardless of ptr.
  - Requester 0 is exempt from quantum expiry. Its slice ends only on done[0] or req[0]=0, and slice_cnt saturates at 15.
  - ptr is not updated when requester 0 releases.
- SCHED_PRIORITY_EN undefined: pure round-robin, and all requesters are subject to QUANTUM.

## Test plan
- Reset, then req=4'b0100 → gnt=4'b0100 and gnt_id=2 one cycle later; done[2] pulsed at slice_cnt=3 → gnt=0 next cycle, and ptr=3.
- req=4'b1111 held, done never asserted, QUANTUM=15 → grants go to 0,1,2,3,0 in order. Each grant lasts 16 cycles, is followed by a 1-cycle gap and one slice_expired pulse.
- Owner 1 with done[1]=1 while slice_cnt==QUANTUM → normal release and slice_expired stays 0. done[3] pulsed while owner is 1 → no effect.
- reset asserted while gnt=4'b0010 and slice_cnt=7 → next cycle all outputs are 0 and slice_expired=0. With req=4'b0011 after reset, the grant goes to 0.
- Owner 2 drops req[2] at slice_cnt=5 → gnt=0 next cycle, slice_expired=0, and the next grant goes to requester 3 if requesting.
- With SCHED_PRIORITY_EN: req=4'b1011 at ptr=1 → grant to 0. Holding req[0] for 40 cycles gives no expiry and slice_cnt saturates at 15.
